load_store_unit: RTL and testbench

//   Initiator side of the data-memory interface: turns byte-addressed load/store requests from the
//   MEM stage into word accesses on the data memory (word-addressed, read sampled on posedge,

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_byte_lane.sv | 41 ++++
 rtl/load_store_unit.sv | 110 +++++++++++
 tb/tb_load_store_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states and the
// alignment rule used to reject requests before any memory access is made.
package lsu_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } lsu_size_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_ERR,
    S_DONE
  } lsu_state_e;

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: is_aligned = 1'b1;
      SZ_HALF: is_aligned = ~offset[0];
      SZ_WORD: is_aligned = (offset == 2'b00);
      default: is_aligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: extracts and extends a loaded byte/half from a memory
// word, and merges store data into a memory word for read-modify-write.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        offset,
  input  logic              is_signed,
  input  logic [WORD_W-1:0] rdata,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] load_data,
  output logic [WORD_W-1:0] merge_data
);

  logic [4:0]        shift;
  logic [WORD_W-1:0] lane;
  logic [WORD_W-1:0] mask;

  // Halfword offsets are always even, so the byte shift also selects the half lane.
  always_comb begin
    shift      = {offset, 3'b000};
    lane       = rdata >> shift;
    mask       = '0;
    load_data  = rdata;
    merge_data = wdata;
    case (size)
      SZ_BYTE: begin
        load_data  = {{24{is_signed & lane[7]}}, lane[7:0]};
        mask       = 32'h0000_00FF << shift;
        merge_data = (rdata & ~mask) | ((wdata & 32'h0000_00FF) << shift);
      end
      SZ_HALF: begin
        load_data  = {{16{is_signed & lane[15]}}, lane[15:0]};
        mask       = 32'h0000_FFFF << shift;
        merge_data = (rdata & ~mask) | ((wdata & 32'h0000_FFFF) << shift);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts byte-addressed requests and turns them into word
// reads/writes on the data memory, with sub-word RMW, sign extension and alignment checks.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [1:0]        ReqSize,
  input  logic              ReqSigned,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [DATA_W-1:0] ReqWData,
  output logic              RespValid,
  output logic              RespError,
  output logic [DATA_W-1:0] RespRData,
  output logic [ADDR_W-3:0] MemAddress,
  output logic [DATA_W-1:0] MemWriteData,
  output logic              MemoryRead,
  output logic              MemoryWrite,
  input  logic [DATA_W-1:0] MemReadData
);

  lsu_state_e        state, state_next;
  logic              accept;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [1:0]        req_off;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merge_data;

  lsu_byte_lane u_lane (
    .size      (req_size),
    .offset    (req_off),
    .is_signed (req_signed),
    .rdata     (MemReadData),
    .wdata     (req_wdata),
    .load_data (load_data),
    .merge_data(merge_data)
  );

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (ReqValid) begin
          accept = 1'b1;
          if (!is_aligned(ReqSize, ReqAddr[1:0]))   state_next = S_ERR;
          else if (ReqWrite && ReqSize == SZ_WORD)  state_next = S_WR;
          else                                      state_next = S_RD;
        end
      end
      S_RD:    state_next = S_CAP;
      S_CAP:   state_next = req_write ? S_WR : S_DONE;
      S_WR:    state_next = S_DONE;
      S_ERR:   state_next = S_IDLE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each strobe lines up with its state.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= S_IDLE;
      ReqReady     <= 1'b1;
      RespValid    <= 1'b0;
      RespError    <= 1'b0;
      RespRData    <= '0;
      MemAddress   <= '0;
      MemWriteData <= '0;
      MemoryRead   <= 1'b0;
      MemoryWrite  <= 1'b0;
      req_write    <= 1'b0;
      req_size     <= '0;
      req_signed   <= 1'b0;
      req_off      <= '0;
      req_wdata    <= '0;
    end else begin
      state       <= state_next;
      ReqReady    <= (state_next == S_IDLE);
      MemoryRead  <= (state_next == S_RD);
      MemoryWrite <= (state_next == S_WR);
      RespValid   <= (state_next == S_DONE) || (state_next == S_ERR);
      RespError   <= (state_next == S_ERR);
      if (accept) begin
        req_write    <= ReqWrite;
        req_size     <= ReqSize;
        req_signed   <= ReqSigned;
        req_off      <= ReqAddr[1:0];
        req_wdata    <= ReqWData;
        MemAddress   <= ReqAddr[ADDR_W-1:2];
        MemWriteData <= ReqWData;
        RespRData    <= '0;
      end
      if (state == S_CAP) begin
        if (req_write) MemWriteData <= merge_data;
        else           RespRData    <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory model on the DUT side, byte-array reference
// model for expected results, directed scenarios plus randomized requests.
module tb_load_store_unit;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        ReqValid, ReqReady, ReqWrite, ReqSigned;
  logic [1:0]  ReqSize;
  logic [7:0]  ReqAddr;
  logic [31:0] ReqWData;
  logic        RespValid, RespError;
  logic [31:0] RespRData;
  logic [5:0]  MemAddress;
  logic [31:0] MemWriteData, MemReadData;
  logic        MemoryRead, MemoryWrite;

  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit #(.ADDR_W(8), .DATA_W(32)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqWrite(ReqWrite), .ReqSize(ReqSize), .ReqSigned(ReqSigned), .ReqAddr(ReqAddr),
    .ReqWData(ReqWData), .RespValid(RespValid), .RespError(RespError), .RespRData(RespRData),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData), .MemoryRead(MemoryRead),
    .MemoryWrite(MemoryWrite), .MemReadData(MemReadData)
  );

  always #5 Clock = ~Clock;

  // Data memory: read sampled at posedge, write committed at negedge.
  logic [31:0] mem [64];
  logic [31:0] rd_q = '0;
  logic        init_done = 1'b0;
  assign MemReadData = rd_q;

  function automatic logic [31:0] init_word(input int w);
    return (32'(w) * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  always @(posedge Clock) if (MemoryRead) rd_q <= mem[MemAddress];
  always @(negedge Clock) begin
    if (!init_done) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (MemoryWrite) begin
      mem[MemAddress] <= MemWriteData;
    end
  end

  // Reference model: flat byte-addressed memory.
  logic [7:0] ref_mem [256];

  function automatic logic ref_legal(input logic [1:0] sz, input logic [7:0] a);
    if (sz == 2'd3) return 1'b0;
    return (int'(a) % (1 << sz)) == 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [7:0] a, input logic [1:0] sz, input logic sg);
    int n;
    longint v;
    n = 1 << sz;
    v = 0;
    for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[int'(a) + i]) << (8 * i));
    if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [7:0] a, input logic [1:0] sz, input logic [31:0] d);
    for (int i = 0; i < (1 << sz); i++) ref_mem[int'(a) + i] = d[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
  endfunction

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic        both;
    logic [5:0]  addr_seen;
    logic        addr_ok;
    logic        busy_ok;
    logic        pulse_ok;
    logic        tmo;
  } resp_t;

  // Issues one request and observes the access until its response. Called #1 after a posedge.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg, input logic [7:0] a,
                        input logic [31:0] wd, input logic keep, output resp_t r);
    int guard;
    r.rdata = '0; r.err = 1'b0; r.lat = -1; r.nrd = 0; r.nwr = 0; r.both = 1'b0;
    r.addr_seen = '0; r.addr_ok = 1'b1; r.busy_ok = 1'b1; r.pulse_ok = 1'b1; r.tmo = 1'b0;
    ReqValid = 1'b1; ReqWrite = wr; ReqSize = sz; ReqSigned = sg; ReqAddr = a; ReqWData = wd;
    guard = 0;
    while (ReqReady !== 1'b1 && guard < 10) begin @(posedge Clock); #1; guard++; end
    if (guard >= 10) begin r.tmo = 1'b1; ReqValid = 1'b0; return; end
    @(posedge Clock); #1;
    if (!keep) ReqValid = 1'b0;
    r.addr_seen = MemAddress;
    guard = 0;
    while (guard < 20) begin
      if (MemoryRead === 1'b1) r.nrd++;
      if (MemoryWrite === 1'b1) r.nwr++;
      if (MemoryRead === 1'b1 && MemoryWrite === 1'b1) r.both = 1'b1;
      if (MemAddress !== r.addr_seen) r.addr_ok = 1'b0;
      if (ReqReady !== 1'b0) r.busy_ok = 1'b0;
      if (RespValid === 1'b1) begin
        r.rdata = RespRData; r.err = RespError; r.lat = guard;
        break;
      end
      @(posedge Clock); #1; guard++;
    end
    if (guard >= 20) begin r.tmo = 1'b1; return; end
    @(posedge Clock); #1;
    r.pulse_ok = (RespValid === 1'b0);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = '0; ReqSigned = 1'b0;
    ReqAddr = '0; ReqWData = '0;
    for (int w = 0; w < 64; w++) begin
      logic [31:0] v;
      v = init_word(w);
      for (int b = 0; b < 4; b++) ref_mem[4*w+b] = v[8*b +: 8];
    end
    repeat (3) @(posedge Clock);
    #1;
    n_checks++; if (ReqReady !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ReqReady); end
    n_checks++; if (RespValid !== 1'b0 || RespError !== 1'b0) begin n_fail++; $display("FAIL reset_resp: got %b%b want 00", RespValid, RespError); end
    n_checks++; if (MemoryRead !== 1'b0 || MemoryWrite !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got %b%b want 00", MemoryRead, MemoryWrite); end
    n_checks++; if (RespRData !== 32'h0 || MemAddress !== 6'h0 || MemWriteData !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got %h/%h/%h want 0/0/0", RespRData, MemAddress, MemWriteData); end
    init_done = 1'b1;
    Reset_n = 1'b1;
    @(posedge Clock); #1;
  endtask

  task automatic test_word();
    resp_t r;
    do_req(1'b1, 2'd2, 1'b0, 8'h10, 32'hDEAD_BEEF, 1'b0, r);
    ref_store(8'h10, 2'd2, 32'hDEAD_BEEF);
    n_checks++; if (r.tmo || r.err !== 1'b0 || r.lat != 1) begin n_fail++; $display("FAIL word_store_resp: tmo=%b err=%b lat=%0d want 0/0/1", r.tmo, r.err, r.lat); end
    n_checks++; if (r.nrd != 0 || r.nwr != 1 || r.rdata !== 32'h0) begin n_fail++; $display("FAIL word_store_strobes: rd=%0d wr=%0d rdata=%h want 0/1/0", r.nrd, r.nwr, r.rdata); end
    n_checks++; if (mem[4] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL word_store_mem: got %h want deadbeef", mem[4]); end
    do_req(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 1'b0, r);
    n_checks++; if (r.tmo || r.rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL word_load_data: got %h want deadbeef", r.rdata); end
    n_checks++; if (r.lat != 2 || r.nrd != 1 || r.nwr != 0) begin n_fail++; $display("FAIL word_load_timing: lat=%0d rd=%0d wr=%0d want 2/1/0", r.lat, r.nrd, r.nwr); end
  endtask

  task automatic test_byte();
    resp_t r;
    do_req(1'b1, 2'd2, 1'b0, 8'h10, 32'h1122_3344, 1'b0, r);
    ref_store(8'h10, 2'd2, 32'h1122_3344);
    do_req(1'b1, 2'd0, 1'b0, 8'h13, 32'hFFFF_FF80, 1'b0, r);
    ref_store(8'h13, 2'd0, 32'h0000_0080);
    n_checks++; if (r.tmo || r.lat != 3 || r.nrd != 1 || r.nwr != 1 || r.both) begin
      n_fail++; $display("FAIL byte_store_seq: lat=%0d rd=%0d wr=%0d both=%b want 3/1/1/0", r.lat, r.nrd, r.nwr, r.both); end
    n_checks++; if (mem[4] !== 32'h8022_3344) begin n_fail++; $display("FAIL byte_store_mem: got %h want 80223344", mem[4]); end
    do_req(1'b0, 2'd0, 1'b1, 8'h13, 32'h0, 1'b0, r);
    n_checks++; if (r.rdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL byte_load_signed: got %h want ffffff80", r.rdata); end
    do_req(1'b0, 2'd0, 1'b0, 8'h13, 32'h0, 1'b0, r);
    n_checks++; if (r.rdata !== 32'h0000_0080) begin n_fail++; $display("FAIL byte_load_unsigned: got %h want 00000080", r.rdata); end
  endtask

  task automatic test_half();
    resp_t r;
    do_req(1'b1, 2'd2, 1'b0, 8'h20, 32'h0, 1'b0, r);
    ref_store(8'h20, 2'd2, 32'h0);
    do_req(1'b1, 2'd1, 1'b0, 8'h22, 32'h1234_ABCD, 1'b0, r);
    ref_store(8'h22, 2'd1, 32'h0000_ABCD);
    n_checks++; if (mem[8] !== 32'hABCD_0000) begin n_fail++; $display("FAIL half_store_mem: got %h want abcd0000", mem[8]); end
    do_req(1'b0, 2'd1, 1'b1, 8'h22, 32'h0, 1'b0, r);
    n_checks++; if (r.rdata !== 32'hFFFF_ABCD || r.lat != 2) begin n_fail++; $display("FAIL half_load_signed: got %h lat %0d want ffffabcd lat 2", r.rdata, r.lat); end
  endtask

  task automatic test_error();
    resp_t r;
    do_req(1'b0, 2'd1, 1'b0, 8'h05, 32'h0, 1'b0, r);
    n_checks++; if (r.tmo || r.err !== 1'b1 || r.lat != 0 || r.rdata !== 32'h0) begin
      n_fail++; $display("FAIL err_half_misaligned: err=%b lat=%0d rdata=%h want 1/0/0", r.err, r.lat, r.rdata); end
    n_checks++; if (r.nrd != 0 || r.nwr != 0) begin n_fail++; $display("FAIL err_half_strobes: rd=%0d wr=%0d want 0/0", r.nrd, r.nwr); end
    do_req(1'b1, 2'd3, 1'b0, 8'h08, 32'h5555_5555, 1'b0, r);
    n_checks++; if (r.tmo || r.err !== 1'b1 || r.lat != 0 || r.nrd != 0 || r.nwr != 0 || r.rdata !== 32'h0) begin
      n_fail++; $display("FAIL err_size11: err=%b lat=%0d rd=%0d wr=%0d rdata=%h want 1/0/0/0/0", r.err, r.lat, r.nrd, r.nwr, r.rdata); end
    n_checks++; if (mem[2] !== ref_word(2)) begin n_fail++; $display("FAIL err_size11_mem: got %h want %h", mem[2], ref_word(2)); end
  endtask

  task automatic test_random();
    resp_t r;
    for (int i = 0; i < 60; i++) begin
      logic wr, sg, legal;
      logic [1:0] sz;
      logic [7:0] a;
      logic [31:0] wd, exp_data;
      int exp_lat, exp_rd, exp_wr;
      wr = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = 8'($urandom);
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~8'((1 << sz) - 1);
      wd = $urandom;
      legal = ref_legal(sz, a);
      exp_data = 32'h0;
      if (!legal) begin exp_lat = 0; exp_rd = 0; exp_wr = 0; end
      else if (!wr) begin exp_lat = 2; exp_rd = 1; exp_wr = 0; exp_data = ref_load(a, sz, sg); end
      else if (sz == 2'd2) begin exp_lat = 1; exp_rd = 0; exp_wr = 1; end
      else begin exp_lat = 3; exp_rd = 1; exp_wr = 1; end
      do_req(wr, sz, sg, a, wd, 1'b0, r);
      if (legal && wr) ref_store(a, sz, wd);
      n_checks++; if (r.tmo || r.err !== !legal || r.rdata !== exp_data) begin
        n_fail++; $display("FAIL rand_resp[%0d]: tmo=%b err=%b rdata=%h want err=%b rdata=%h", i, r.tmo, r.err, r.rdata, !legal, exp_data); end
      n_checks++; if (r.lat != exp_lat || r.nrd != exp_rd || r.nwr != exp_wr || r.both) begin
        n_fail++; $display("FAIL rand_seq[%0d]: lat=%0d rd=%0d wr=%0d both=%b want %0d/%0d/%0d/0", i, r.lat, r.nrd, r.nwr, r.both, exp_lat, exp_rd, exp_wr); end
      n_checks++; if (!r.addr_ok || r.addr_seen !== a[7:2] || !r.pulse_ok || !r.busy_ok) begin
        n_fail++; $display("FAIL rand_ctrl[%0d]: addr=%h stable=%b pulse=%b busy=%b want addr=%h 1/1/1", i, r.addr_seen, r.addr_ok, r.pulse_ok, r.busy_ok, a[7:2]); end
      n_checks++; if (mem[a[7:2]] !== ref_word(int'(a[7:2]))) begin
        n_fail++; $display("FAIL rand_mem[%0d]: word %0d got %h want %h", i, a[7:2], mem[a[7:2]], ref_word(int'(a[7:2]))); end
    end
  endtask

  task automatic test_back_to_back();
    resp_t r;
    logic [7:0] addrs [6] = '{8'hFC, 8'hFF, 8'hFE, 8'hFC, 8'h01, 8'h00};
    logic [1:0] sizes [6] = '{2'd2, 2'd0, 2'd1, 2'd2, 2'd1, 2'd2};
    logic       wrs   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      logic [31:0] wd, exp_data;
      logic legal;
      wd = $urandom;
      legal = ref_legal(sizes[i], addrs[i]);
      exp_data = (legal && !wrs[i]) ? ref_load(addrs[i], sizes[i], 1'b0) : 32'h0;
      do_req(wrs[i], sizes[i], 1'b0, addrs[i], wd, 1'b1, r);
      if (legal && wrs[i]) ref_store(addrs[i], sizes[i], wd);
      n_checks++; if (r.tmo || r.err !== !legal || r.rdata !== exp_data || !r.busy_ok || !r.pulse_ok) begin
        n_fail++; $display("FAIL b2b_resp[%0d]: tmo=%b err=%b rdata=%h busy=%b pulse=%b want err=%b rdata=%h", i, r.tmo, r.err, r.rdata, r.busy_ok, r.pulse_ok, !legal, exp_data); end
      n_checks++; if (r.nrd != ((legal && !(wrs[i] && sizes[i] == 2'd2)) ? 1 : 0) || r.nwr != ((legal && wrs[i]) ? 1 : 0) || r.both) begin
        n_fail++; $display("FAIL b2b_strobes[%0d]: rd=%0d wr=%0d both=%b", i, r.nrd, r.nwr, r.both); end
      n_checks++; if (r.addr_seen !== addrs[i][7:2] || !r.addr_ok) begin
        n_fail++; $display("FAIL b2b_addr[%0d]: got %0d stable=%b want %0d", i, r.addr_seen, r.addr_ok, addrs[i][7:2]); end
    end
    ReqValid = 1'b0;
    n_checks++; if (mem[63] !== ref_word(63)) begin n_fail++; $display("FAIL b2b_wrap_mem: got %h want %h", mem[63], ref_word(63)); end
    @(posedge Clock); #1;
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] old;
    old = mem[5];
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'd2; ReqSigned = 1'b0; ReqAddr = 8'h14; ReqWData = 32'hCAFE_F00D;
    n_checks++; if (ReqReady !== 1'b1) begin n_fail++; $display("FAIL rst_pre_ready: got %b want 1", ReqReady); end
    @(posedge Clock); #1;
    ReqValid = 1'b0;
    n_checks++; if (MemoryWrite !== 1'b1) begin n_fail++; $display("FAIL rst_in_wr: MemoryWrite got %b want 1", MemoryWrite); end
    Reset_n = 1'b0;
    #1;
    n_checks++; if (MemoryWrite !== 1'b0 || MemoryRead !== 1'b0) begin n_fail++; $display("FAIL rst_strobe_drop: got %b%b want 00", MemoryRead, MemoryWrite); end
    @(negedge Clock); #1;
    n_checks++; if (mem[5] !== old) begin n_fail++; $display("FAIL rst_write_suppressed: got %h want %h", mem[5], old); end
    @(posedge Clock); #1;
    Reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (RespValid !== 1'b0) begin n_fail++; $display("FAIL rst_no_resp[%0d]: got %b want 0", c, RespValid); end
      @(posedge Clock); #1;
    end
    n_checks++; if (ReqReady !== 1'b1) begin n_fail++; $display("FAIL rst_post_ready: got %b want 1", ReqReady); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_error();
    test_random();
    test_back_to_back();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
